pong_game_controller: RTL
=========================

// Module: pong_game_controller
// PURPOSE
//   Game-flow sequencer for Pong. Consumes UART key bytes, the game-tick strobe and the
//   ball's score pulses. Drives ball enable/reset, serve direction, paddle enable, both
//   scores and the winner. Sits between the UART receiver / game-tick divider and the
//   ball/paddle behaviour blocks; all logic runs on the pixel-domain clock i_CLK.
// PARAMETERS
//   WIN_SCORE    7    points needed to win; 1..15
//   SERVE_TICKS  60   game ticks spent in SERVE before the ball is released
//   POINT_TICKS  90   game ticks the ball stays frozen after a point
//   START_KEY    32   ASCII start key (space); starts a game from IDLE or OVER
//   PAUSE_KEY    112  ASCII pause key ('p'); used only with PONG_PAUSE_EN
// PORTS
//   i_CLK          in   1  system clock
//   i_RST          in   1  synchronous reset, active-high
//   i_tick         in   1  one-cycle game-tick strobe
//   i_key_valid    in   1  one-cycle strobe; i_key_byte is valid
//   i_key_byte     in   8  received ASCII byte
//   i_p1_scored    in   1  one-cycle pulse; P1 scored
//   i_p2_scored    in   1  one-cycle pulse; P2 scored
//   o_ball_en      out  1  ball motion enable
//   o_ball_reset   out  1  hold ball at centre
//   o_serve_dir    out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
//   o_paddles_en   out  1  paddle motion enable
//   o_p1_score     out  4  P1 score
//   o_p2_score     out  4  P2 score
//   o_winner       out  2  0 none, 1 P1, 2 P2
//   o_state        out  3  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 PAUSE=5
// BEHAVIOUR
// - Reset
//   - i_RST overrides all other inputs, including mid-game.
//   - Reset values: state IDLE, scores 0, winner 0, serve_dir 0, ball_en 0,
//     ball_reset 1, paddles_en 0, tick counter 0.
// - Outputs
//   - All outputs are registered Moore outputs. They change on the same edge as the state.
//   - Per-state values (ball_en / ball_reset / paddles_en):
//     - IDLE 0/1/0
//     - SERVE 0/1/1
//     - PLAY 1/0/1
//     - POINT 0/0/0: ball frozen in place
//     - OVER 0/1/0
//     - PAUSE 0/0/0
// - Key handling
//   - A key counts only when i_key_valid=1 and i_key_byte matches. All other bytes are ignored.
// - IDLE / OVER
//   - START_KEY: go to SERVE; scores 0; winner 0; counter=SERVE_TICKS; serve_dir unchanged.
// - SERVE / POINT counter
//   - Counter decrements once per i_tick.
//   - When counter==0, the next edge leaves the state: SERVE -> PLAY; POINT -> SERVE with
//     counter=SERVE_TICKS.
//   - Each state therefore lasts exactly N ticks. A value of 0 leaves after one cycle.
// - PLAY, scoring
//   - i_p1_scored alone: p1_score+1; serve_dir=1.
//     - If new score == WIN_SCORE: go to OVER, winner=1.
//     - Otherwise: go to POINT, counter=POINT_TICKS.
//   - i_p2_scored: mirror image (serve_dir=0, winner=2).
//   - Both pulses in the same cycle: no score change; go to POINT (replay); serve_dir unchanged.
//   - Score pulses are ignored in every state except PLAY.
//   - Scores never exceed WIN_SCORE.
// - Simultaneous events
//   - i_tick, key and score pulses in one cycle are all evaluated against the current state.
//     A scoring transition wins over a pause key.
// CONFIGURATION
//   PONG_PAUSE_EN
//   - Defined:
//     - In PLAY, PAUSE_KEY -> PAUSE.
//     - In PAUSE, PAUSE_KEY -> PLAY.
//     - Score pulses and ticks are ignored while paused; scores and serve_dir are held.
//     - START_KEY has no effect in PAUSE.
//   - Undefined:
//     - PAUSE_KEY is ignored and state 5 is unreachable.
// TESTING
// 1. Assert i_RST for 2 cycles -> o_state=0, o_ball_reset=1, both scores 0, o_winner=0.
// 2. In IDLE send key 32, then 60 i_tick pulses -> SERVE for exactly 60 ticks, then o_state=2,
//    o_ball_en=1.
// 3. In PLAY pulse i_p1_scored -> p1_score=1, serve_dir=1, POINT. After 90 ticks -> SERVE.
//    After 60 more ticks -> PLAY.
// 4. Drive P2 to 6 points, then pulse i_p2_scored -> p2_score=7, o_winner=2, OVER.
//    Send key 32 -> SERVE, scores 0, o_winner=0.
// 5. Pulse i_p1_scored and i_p2_scored in the same cycle -> scores unchanged, POINT.
//    Score pulses sent in POINT -> ignored.
// 6. PONG_PAUSE_EN: in PLAY send 112 -> o_state=5, o_ball_en=0. i_p1_scored -> no change.
//    Send 112 -> PLAY. Then assert i_RST in PLAY -> IDLE.

Source files
------------

// File: rtl/pong_game_controller_if.sv
// Control/status bundle between the Pong game-flow sequencer and its surroundings.
interface pong_game_controller_if;
    logic       tick;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       p1_scored;
    logic       p2_scored;
    logic       ball_en;
    logic       ball_reset;
    logic       serve_dir;
    logic       paddles_en;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output tick, key_valid, key_byte, p1_scored, p2_scored,
        input  ball_en, ball_reset, serve_dir, paddles_en, p1_score, p2_score, winner, state
    );

    modport slave (
        input  tick, key_valid, key_byte, p1_scored, p2_scored,
        output ball_en, ball_reset, serve_dir, paddles_en, p1_score, p2_score, winner, state
    );
endinterface

// File: rtl/pong_game_controller.sv
// Pong game-flow sequencer: keys/ticks/score pulses in, registered Moore control out, 1-cycle latency.
// No backpressure; optional pause state enabled by defining PONG_PAUSE_EN.
module pong_game_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int START_KEY   = 32,
    parameter int PAUSE_KEY   = 112
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    pong_game_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;

`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [3:0]       p1_q, p1_nx;
    logic [3:0]       p2_q, p2_nx;
    logic [1:0]       winner_q, winner_nx;
    logic             serve_dir_q, serve_dir_nx;
    logic             ball_en_q, ball_reset_q, paddles_en_q;

    logic key_start;
    logic key_pause;
    logic p1_only;
    logic p2_only;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign key_start = bus.key_valid && (bus.key_byte == 8'(START_KEY));
    assign key_pause = bus.key_valid && (bus.key_byte == 8'(PAUSE_KEY)) && PAUSE_EN;
    assign p1_only   = bus.p1_scored && !bus.p2_scored;
    assign p2_only   = bus.p2_scored && !bus.p1_scored;
    assign p1_inc    = p1_q + 4'd1;
    assign p2_inc    = p2_q + 4'd1;

    always_comb begin
        state_nx     = state_q;
        cnt_nx       = cnt_q;
        p1_nx        = p1_q;
        p2_nx        = p2_q;
        winner_nx    = winner_q;
        serve_dir_nx = serve_dir_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (key_start) begin
                    state_nx  = ST_SERVE;
                    cnt_nx    = CNT_W'(SERVE_TICKS);
                    p1_nx     = 4'd0;
                    p2_nx     = 4'd0;
                    winner_nx = 2'd0;
                end
            end
            ST_SERVE: begin
                if (cnt_q == '0) begin
                    state_nx = ST_PLAY;
                end else if (bus.tick) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_POINT: begin
                if (cnt_q == '0) begin
                    state_nx = ST_SERVE;
                    cnt_nx   = CNT_W'(SERVE_TICKS);
                end else if (bus.tick) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            ST_PLAY: begin
                // Scoring has priority over a pause key arriving in the same cycle.
                if (p1_only) begin
                    p1_nx        = p1_inc;
                    serve_dir_nx = 1'b1;
                    if (p1_inc == 4'(WIN_SCORE)) begin
                        state_nx  = ST_OVER;
                        winner_nx = 2'd1;
                    end else begin
                        state_nx = ST_POINT;
                        cnt_nx   = CNT_W'(POINT_TICKS);
                    end
                end else if (p2_only) begin
                    p2_nx        = p2_inc;
                    serve_dir_nx = 1'b0;
                    if (p2_inc == 4'(WIN_SCORE)) begin
                        state_nx  = ST_OVER;
                        winner_nx = 2'd2;
                    end else begin
                        state_nx = ST_POINT;
                        cnt_nx   = CNT_W'(POINT_TICKS);
                    end
                end else if (bus.p1_scored && bus.p2_scored) begin
                    state_nx = ST_POINT;
                    cnt_nx   = CNT_W'(POINT_TICKS);
                end else if (key_pause) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (key_pause) begin
                    state_nx = ST_PLAY;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Control outputs decode the next state so they move on the same edge as state_q.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 2'd0;
            serve_dir_q  <= 1'b0;
            ball_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            paddles_en_q <= 1'b0;
        end else begin
            state_q      <= state_nx;
            cnt_q        <= cnt_nx;
            p1_q         <= p1_nx;
            p2_q         <= p2_nx;
            winner_q     <= winner_nx;
            serve_dir_q  <= serve_dir_nx;
            ball_en_q    <= (state_nx == ST_PLAY);
            ball_reset_q <= (state_nx == ST_IDLE) || (state_nx == ST_SERVE) || (state_nx == ST_OVER);
            paddles_en_q <= (state_nx == ST_SERVE) || (state_nx == ST_PLAY);
        end
    end

    assign bus.state      = state_q;
    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.winner     = winner_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.ball_en    = ball_en_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.paddles_en = paddles_en_q;
endmodule
